// File: rtl/wb_spram_bridge.sv
// Wishbone B4 pipelined slave bridging to a single-port, byte-enabled,
// 1-cycle registered-read RAM. One RAM access per cycle, in-order responses.
// Optional feature macro: WB_SPRAM_ADDR_ERR_EN (out-of-window requests get
// wb_err instead of a RAM access; otherwise addresses alias).
module wb_spram_bridge #(
  parameter int          MEMSIZE   = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          OUTREG    = 0,
  localparam int         AWIDTH    = $clog2(MEMSIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [31:0]       wb_adr,
  input  logic [3:0]        wb_sel,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_stall,
  output logic              wb_ack,
  output logic              wb_err,
  output logic [31:0]       wb_dat_o,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [AWIDTH-1:0] ram_address,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_data,
  input  logic [31:0]       ram_q
);

  typedef enum logic {INIT, RUN} state_t;

  state_t      state_q, state_nxt;
  logic        accept;
  logic [31:0] offset;
  logic        req_err;

  logic        vld_p0, rd_p0, err_p0;
  logic        vld_out, err_out;
  logic [31:0] dat_out;

  // Control state register: one idle cycle after reset before accepting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_nxt;
  end

  // Next state and stall; stall is forced while reset is held.
  always_comb begin
    state_nxt = state_q;
    wb_stall  = 1'b1;
    case (state_q)
      INIT:    state_nxt = RUN;
      RUN:     wb_stall  = 1'b0;
      default: state_nxt = INIT;
    endcase
    if (reset) wb_stall = 1'b1;
  end

  assign accept = wb_cyc & wb_stb & ~wb_stall;
  assign offset = wb_adr - BASE_ADDR;

`ifdef WB_SPRAM_ADDR_ERR_EN
  // Widened compare so a window reaching the top of the address space still works.
  assign req_err = ({1'b0, offset} >= 33'(4 * MEMSIZE));
`else
  logic unused_offset_bits;
  assign req_err            = 1'b0;
  assign unused_offset_bits = ^{offset[31:AWIDTH+2], offset[1:0]};
`endif

  // RAM sees the request combinationally in the accept cycle.
  assign ram_address = offset[AWIDTH+1:2];
  assign ram_rden    = accept & ~wb_we & ~req_err;
  assign ram_wren    = accept & wb_we & (|wb_sel) & ~req_err;
  assign ram_byteena = wb_sel;
  assign ram_data    = wb_dat_i;

  // Stage p0: request accepted last cycle; RAM read data is on ram_q now.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      rd_p0  <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      rd_p0  <= accept & ~wb_we & ~req_err;
      err_p0 <= accept & req_err;
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic        vld_p1, err_p1;
      logic [31:0] dat_p1;

      // Stage p1 control: dropping wb_cyc kills the in-flight response.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_p1 <= 1'b0;
          err_p1 <= 1'b0;
        end else begin
          vld_p1 <= vld_p0 & wb_cyc;
          err_p1 <= err_p0;
        end
      end

      // Stage p1 data: registered copy of RAM output, zero for non-reads.
      always_ff @(posedge clock) begin
        dat_p1 <= rd_p0 ? ram_q : 32'h0;
      end

      assign vld_out = vld_p1;
      assign err_out = err_p1;
      assign dat_out = dat_p1;
    end else begin : g_direct
      assign vld_out = vld_p0;
      assign err_out = err_p0;
      assign dat_out = rd_p0 ? ram_q : 32'h0;
    end
  endgenerate

  // Responses are suppressed in the cycle wb_cyc drops (abort).
  assign wb_ack   = vld_out & ~err_out & wb_cyc;
`ifdef WB_SPRAM_ADDR_ERR_EN
  assign wb_err   = vld_out & err_out & wb_cyc;
`else
  assign wb_err   = 1'b0;
`endif
  assign wb_dat_o = wb_ack ? dat_out : 32'h0;

endmodule

// File: tb/tb_wb_spram_bridge.sv
// Bench for wb_spram_bridge: two instances (OUTREG=0 and OUTREG=1) share the
// same bus stimulus, each with its own behavioural RAM.
module tb_wb_spram_bridge;

  localparam int AW = 14;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        cyc, stb, we;
  logic [31:0] adr, dati;
  logic [3:0]  sel;

  logic          stall0, ack0, err0, rden0, wren0;
  logic [31:0]   dato0, data0, q0;
  logic [AW-1:0] addr0;
  logic [3:0]    be0;

  logic          stall1, ack1, err1, rden1, wren1;
  logic [31:0]   dato1, data1, q1;
  logic [AW-1:0] addr1;
  logic [3:0]    be1;

  int n_chk  = 0;
  int n_fail = 0;

  wb_spram_bridge #(.OUTREG(0)) u_dut0 (
    .clock(clock), .reset(reset), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_sel(sel), .wb_dat_i(dati), .wb_stall(stall0),
    .wb_ack(ack0), .wb_err(err0), .wb_dat_o(dato0), .ram_rden(rden0),
    .ram_wren(wren0), .ram_address(addr0), .ram_byteena(be0),
    .ram_data(data0), .ram_q(q0)
  );

  wb_spram_bridge #(.OUTREG(1)) u_dut1 (
    .clock(clock), .reset(reset), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_sel(sel), .wb_dat_i(dati), .wb_stall(stall1),
    .wb_ack(ack1), .wb_err(err1), .wb_dat_o(dato1), .ram_rden(rden1),
    .ram_wren(wren1), .ram_address(addr1), .ram_byteena(be1),
    .ram_data(data1), .ram_q(q1)
  );

  logic [31:0] mem0 [0:16383];
  logic [31:0] mem1 [0:16383];

  // Byte-enabled single-port RAM with one-cycle registered read.
  always @(posedge clock) begin
    if (wren0) for (int b = 0; b < 4; b++) if (be0[b]) mem0[addr0][8*b +: 8] <= data0[8*b +: 8];
    if (rden0) q0 <= mem0[addr0];
  end

  always @(posedge clock) begin
    if (wren1) for (int b = 0; b < 4; b++) if (be1[b]) mem1[addr1][8*b +: 8] <= data1[8*b +: 8];
    if (rden1) q1 <= mem1[addr1];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [3:0] bs, input logic [31:0] d);
    cyc = c; stb = s; we = w; adr = a; sel = bs; dati = d;
  endtask

  function automatic logic [31:0] val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // One isolated transaction; checks RAM drive, then both response latencies.
  task automatic single(input logic w, input logic [31:0] a, input logic [3:0] bs,
                        input logic [31:0] d, input logic [31:0] ed, input logic ee);
    tick;
    drive(1'b1, 1'b1, w, a, bs, d);
    @(negedge clock);
    check("req_stall", stall0, 1'b0);
    check("ram_rden", rden0, !w && !ee);
    check("ram_wren", wren0, w && (|bs) && !ee);
    check("ram_address", 32'(addr0), 32'(a[AW+1:2]));
    check("ram_byteena", be0, bs);
    check("ram_data", data0, d);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check("ack_lat1", ack0, !ee);
    check("err_lat1", err0, ee);
    check("dat_lat1", dato0, (w || ee) ? 32'h0 : ed);
    check("ack_outreg_early", ack1, 1'b0);
    tick;
    @(negedge clock);
    check("ack_lat2", ack1, !ee);
    check("err_lat2", err1, ee);
    check("dat_lat2", dato1, (w || ee) ? 32'h0 : ed);
    check("ack_lat1_single", ack0, 1'b0);
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Eight back-to-back requests to words 0..7, then drain.
  task automatic stream(input logic w);
    for (int c = 0; c < 10; c++) begin
      tick;
      if (c < 8) drive(1'b1, 1'b1, w, 32'(c * 4), 4'hF, val(c));
      else       drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clock);
      if (c < 8) check("stream_stall", stall0, 1'b0);
      check("stream_ack0", ack0, (c >= 1 && c <= 8));
      check("stream_ack1", ack1, (c >= 2 && c <= 9));
      if (!w && c >= 1 && c <= 8) check("stream_dat0", dato0, val(c - 1));
      if (!w && c >= 2) check("stream_dat1", dato1, val(c - 2));
    end
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("rst_stall", stall0, 1'b1);
    check("rst_ack", ack0, 1'b0);
    check("rst_err", err0, 1'b0);
    check("rst_dat", dato0, 32'h0);
    check("rst_ack1", ack1, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    @(negedge clock);
    check("init_stall", stall0, 1'b1);
    tick;
    @(negedge clock);
    check("run_stall0", stall0, 1'b0);
    check("run_stall1", stall1, 1'b0);

    // Full-word write then read back.
    single(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    single(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);

    // Single byte lane update.
    single(1'b1, 32'h10, 4'b0010, 32'h00001100, 32'h0, 1'b0);
    single(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD11EF, 1'b0);

    // Zero byte-select write: no RAM write, still acked.
    single(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0);
    single(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD11EF, 1'b0);

    // Streaming writes then reads.
    stream(1'b1);
    stream(1'b0);

    // Abort a read.
    tick;
    drive(1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check("abort_rd_ack0", ack0, 1'b0);
    tick;
    @(negedge clock);
    check("abort_rd_ack1", ack1, 1'b0);

    // Abort a write: no ack, data still committed.
    tick;
    drive(1'b1, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
    @(negedge clock);
    check("abort_wr_wren", wren0, 1'b1);
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check("abort_wr_ack0", ack0, 1'b0);
    tick;
    @(negedge clock);
    check("abort_wr_ack1", ack1, 1'b0);
    single(1'b0, 32'h20, 4'hF, 32'h0, 32'h12345678, 1'b0);

    // Out-of-window access.
`ifdef WB_SPRAM_ADDR_ERR_EN
    single(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0, 1'b1);
    single(1'b1, 32'h0001_0004, 4'hF, 32'hBAD0BAD0, 32'h0, 1'b1);
    single(1'b0, 32'h4, 4'hF, 32'h0, val(1), 1'b0);
`else
    single(1'b0, 32'h0001_0000, 4'hF, 32'h0, val(0), 1'b0);
`endif

    // Asynchronous reset with two reads in flight.
    tick;
    drive(1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    tick;
    drive(1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    check("pre_rst_ack1", ack1, 1'b1);
    check("pre_rst_dat1", dato1, val(1));
    check("pre_rst_ack0", ack0, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_ack1", ack1, 1'b0);
    check("async_rst_ack0", ack0, 1'b0);
    check("async_rst_dat1", dato1, 32'h0);
    check("async_rst_stall1", stall1, 1'b1);
    tick;
    tick;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ack1", ack1, 1'b0);
    check("post_rst_stall1", stall1, 1'b1);
    tick;
    @(negedge clock);
    check("post_rst_ack1_b", ack1, 1'b0);
    check("post_rst_stall1_b", stall1, 1'b0);
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_spram_bridge.md
Name: wb_spram_bridge

Overview:
- Wishbone B4 pipelined slave that drives the 16384x32 single-port on-chip RAM (byte-enabled, 1-cycle registered read) directly upstream of it.
- Translates byte addresses to word addresses, issues one RAM read or write per cycle, and tracks the RAM read latency.
- Returns ack/err in request order with zero stall in steady state; used for the SoC instruction/data RAM.

Parameters:
- MEMSIZE, 16384, RAM depth in 32-bit words; AWIDTH = $clog2(MEMSIZE) is derived.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be aligned to 4*MEMSIZE.
- OUTREG, 0, 1 adds a registered output stage on read data (response latency 2 instead of 1).

Ports:
- clock, input, 1, system clock, all logic on rising edge.
- reset, input, 1, asynchronous active-high reset.
- wb_cyc, input, 1, bus cycle.
- wb_stb, input, 1, request strobe.
- wb_we, input, 1, 1 = write.
- wb_adr, input, 32, byte address.
- wb_sel, input, 4, byte lane selects.
- wb_dat_i, input, 32, write data.
- wb_stall, output, 1, request not accepted this cycle.
- wb_ack, output, 1, response valid.
- wb_err, output, 1, error response (feature only; otherwise tied 0).
- wb_dat_o, output, 32, read data, valid with wb_ack.
- ram_rden, output, 1, RAM read enable.
- ram_wren, output, 1, RAM write enable.
- ram_address, output, AWIDTH, RAM word address.
- ram_byteena, output, 4, RAM byte enables.
- ram_data, output, 32, RAM write data.
- ram_q, input, 32, RAM read data, valid 1 cycle after ram_rden.

Behaviour:
- States: INIT, RUN.
  - Reset forces INIT; INIT -> RUN on the first clock after reset deasserts.
  - wb_stall = 1 in INIT and during reset, 0 in RUN.
- Reset values: wb_ack=0, wb_err=0, wb_dat_o=0, wb_stall=1; pipeline valid bits cleared.
- accept = wb_cyc & wb_stb & !wb_stall.
- RAM drive is combinational from the Wishbone request, so the RAM sees the request in the accept cycle:
  - ram_address = (wb_adr - BASE_ADDR)[AWIDTH+1:2]; wb_adr[1:0] ignored.
  - ram_rden = accept & !wb_we.
  - ram_wren = accept & wb_we & |wb_sel; sel=4'b0000 writes nothing but is still acked.
  - ram_byteena = wb_sel; ram_data = wb_dat_i.
- Response latency, with the request accepted at cycle N:
  - OUTREG=0: wb_ack at N+1; wb_dat_o = ram_q for reads.
  - OUTREG=1: ram_q is registered at N+1; wb_ack at N+2.
  - Writes use the same latency as reads, so responses are strictly in order.
  - wb_dat_o = 0 on write acks.
- Back-to-back accepts (one per cycle, any mix of read and write) give one ack per cycle, no bubbles.
- Outstanding count is at most 1+OUTREG; no overflow is possible because the RAM latency is fixed.
- wb_cyc low: every in-flight valid bit is cleared on the same edge.
  - No ack/err is issued for aborted requests.
  - A write already presented to the RAM stays committed.
- Without the feature, addresses outside the window alias modulo 4*MEMSIZE and are acked normally.
- reset mid-transaction: in-flight responses are dropped; outputs return to reset values asynchronously.

Optional Feature:
- Macro: WB_SPRAM_ADDR_ERR_EN.
- Defined:
  - Request with (wb_adr - BASE_ADDR) >= 4*MEMSIZE (unsigned) issues no RAM access (ram_rden=ram_wren=0).
  - It returns wb_err=1, wb_ack=0, wb_dat_o=0 at the normal response latency, in order with other responses.
- Undefined: wb_err is tied 0; out-of-window addresses alias as above.

Test Plan:
1. Reset, OUTREG=0: wb_stall=1 until one clock after reset release. Write 32'hDEADBEEF to 0x10 with sel=4'hF; read 0x10 -> ack 1 cycle after each accept, read data 32'hDEADBEEF.
2. Byte-lane write: after test 1, write 32'h00001100 to 0x10 with sel=4'b0010; read 0x10 -> 32'hDEAD11EF; also check ram_byteena=4'b0010 during the write.
3. Back-to-back streaming: 8 consecutive reads of 0x0..0x1C with stb held high -> 8 consecutive acks, no stall, data in order. Repeat with OUTREG=1 -> first ack 2 cycles after first accept, then 8 consecutive acks.
4. Abort: issue a read, then drop wb_cyc in the next cycle -> no ack seen. Issue a write, then drop cyc -> no ack, but a later read returns the new data.
5. Out of window, BASE_ADDR=0: access 0x0001_0000. Feature on -> wb_err at latency 1, no RAM enables. Feature off -> aliases to word 0 and is acked.
6. Async reset asserted with 2 reads in flight (OUTREG=1) -> wb_ack drops immediately; no stale ack after reset release.
